// File: rtl/fpmul_issue_stage_if.sv
// Operand/result handshake bundle between FPU issue logic, the multiply stage and writeback.
interface fpmul_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fpmul_issue_stage.sv
// Multicycle handshake wrapper around the combinational FP64 multiplier: holds operands
// for LATENCY cycles, captures the product with IEEE exception flags, and waits for writeback.
module fpmul_issue_stage #(
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpmul_issue_stage_if.slave   bus,
  output logic [63:0]          op_a,
  output logic [63:0]          op_b,
  input  logic [63:0]          mul_result,
  input  logic                 flush,
  output logic [3:0]           fflags,
  input  logic                 fflags_clr
);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept, sample, retire;

  logic [10:0] ea, eb;
  logic [51:0] ma, mb;
  logic        inf_a, inf_b, nan_a, nan_b, z_a, z_b;
  logic        nv, of, uf;
  logic [3:0]  flags_nx;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // flush takes precedence over both an accept and a retiring handshake
  assign accept = bus.in_valid && (state == IDLE) && !flush;
  assign sample = (state == BUSY) && (cnt == CW'(1)) && !flush;
  assign retire = (state == DONE) && bus.out_ready && !flush;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: begin
        if (flush)       state_nx = IDLE;
        else if (sample) state_nx = DONE;
      end
      DONE: if (flush || bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign ea = op_a[62:52];
  assign eb = op_b[62:52];
  assign ma = op_a[51:0];
  assign mb = op_b[51:0];

  always_comb begin
    inf_a = (ea == 11'h7FF) && (ma == '0);
    inf_b = (eb == 11'h7FF) && (mb == '0);
    nan_a = (ea == 11'h7FF) && (ma != '0);
    nan_b = (eb == 11'h7FF) && (mb != '0);
    z_a   = (ea == '0);
    z_b   = (eb == '0);
    nv    = nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a);
    of    = !nv && !inf_a && !inf_b && (mul_result[62:52] == 11'h7FF);
    uf    = !nv && !z_a && !z_b && !inf_a && !inf_b && (mul_result[62:0] == '0);
    flags_nx = {nv, of, uf, of || uf};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a          <= '0;
      op_b          <= '0;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_flags <= '0;
      fflags        <= '0;
    end else begin
      if (accept) begin
        op_a <= bus.in_a;
        op_b <= bus.in_b;
        cnt  <= CW'(LATENCY);
      end else if (state == BUSY && !flush) begin
        cnt <= cnt - CW'(1);
      end

      if (sample) begin
        bus.out_data  <= mul_result;
        bus.out_flags <= flags_nx;
      end

      // a retiring result's flags survive a simultaneous clear
      if (retire)          fflags <= (fflags_clr ? '0 : fflags) | bus.out_flags;
      else if (fflags_clr) fflags <= '0;
    end
  end
endmodule

// File: tb/tb_fpmul_issue_stage.sv
// Directed self-checking bench for fpmul_issue_stage; a small lookup table stands in for the multiplier.
module tb_fpmul_issue_stage;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] op_a, op_b, mul_result;
  logic        flush, fflags_clr;
  logic [3:0]  fflags;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] held;

  fpmul_issue_stage_if bus ();

  fpmul_issue_stage #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_result (mul_result),
    .flush      (flush),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
  );

  always #5 clk = ~clk;

  // hand-computed products for the operand pairs used below
  always_comb begin
    mul_result = 64'h0;
    case ({op_a, op_b})
      {64'h4000000000000000, 64'h4008000000000000}: mul_result = 64'h4018000000000000;
      {64'h7FE0000000000000, 64'h4000000000000000}: mul_result = 64'h7FF0000000000000;
      {64'h7FF0000000000000, 64'h0000000000000000}: mul_result = 64'h7FF8000000000000;
      {64'h0010000000000000, 64'h0010000000000000}: mul_result = 64'h0000000000000000;
      {64'h3FF0000000000000, 64'h3FF0000000000000}: mul_result = 64'h3FF0000000000000;
      default: mul_result = 64'h0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // accept one pair and walk it to DONE, checking the exact latency
  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    chk("busy_in_ready", 64'(bus.in_ready), 64'h0);
    chk("busy_op_a", op_a, a);
    chk("busy_op_b", op_b, b);
    for (int unsigned i = 1; i < LAT; i++) begin
      tick();
      chk("busy_no_valid", 64'(bus.out_valid), 64'h0);
    end
    tick();
    chk("done_valid", 64'(bus.out_valid), 64'h1);
  endtask

  task automatic retire_op;
    bus.out_ready = 1'b1;
    chk("retire_in_ready_low", 64'(bus.in_ready), 64'h0);
    tick();
    bus.out_ready = 1'b0;
    chk("retire_valid_low", 64'(bus.out_valid), 64'h0);
    chk("retire_in_ready", 64'(bus.in_ready), 64'h1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_op_a", op_a, 64'h0);
    chk("rst_out_data", bus.out_data, 64'h0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'h0);
    chk("rst_fflags", 64'(fflags), 64'h0);

    issue(64'h4000000000000000, 64'h4008000000000000);
    chk("mul_data", bus.out_data, 64'h4018000000000000);
    chk("mul_flags", 64'(bus.out_flags), 64'h0);
    retire_op();
    chk("mul_fflags", 64'(fflags), 64'h0);

    issue(64'h7FE0000000000000, 64'h4000000000000000);
    chk("of_data", bus.out_data, 64'h7FF0000000000000);
    chk("of_flags", 64'(bus.out_flags), 64'h5);
    retire_op();
    chk("of_fflags", 64'(fflags), 64'h5);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    chk("clr_fflags", 64'(fflags), 64'h0);

    issue(64'h7FF0000000000000, 64'h0000000000000000);
    chk("nv_flags", 64'(bus.out_flags), 64'h8);
    retire_op();
    chk("nv_fflags", 64'(fflags), 64'h8);

    issue(64'h0010000000000000, 64'h0010000000000000);
    chk("uf_data", bus.out_data, 64'h0);
    chk("uf_flags", 64'(bus.out_flags), 64'h3);
    fflags_clr = 1'b1;
    retire_op();
    fflags_clr = 1'b0;
    chk("clr_and_retire_fflags", 64'(fflags), 64'h3);

    issue(64'h4000000000000000, 64'h4008000000000000);
    held = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_a = 64'h3FF0000000000000;
    bus.in_b = 64'h3FF0000000000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_data", bus.out_data, held);
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
      chk("bp_op_a", op_a, 64'h4000000000000000);
    end
    bus.in_valid = 1'b0;
    retire_op();
    chk("bp_fflags", 64'(fflags), 64'h3);

    bus.in_valid = 1'b1;
    bus.in_a = 64'h7FE0000000000000;
    bus.in_b = 64'h4000000000000000;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("idle_flush_no_accept", 64'(bus.in_ready), 64'h1);
    chk("idle_flush_op_a", op_a, 64'h4000000000000000);

    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 64'h1);
    chk("flush_valid", 64'(bus.out_valid), 64'h0);
    tick();
    chk("flush_still_idle", 64'(bus.out_valid), 64'h0);
    chk("flush_fflags", 64'(fflags), 64'h3);

    issue(64'h7FE0000000000000, 64'h4000000000000000);
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    chk("rst_done_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_done_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_done_fflags", 64'(fflags), 64'h0);
    chk("rst_done_data", bus.out_data, 64'h0);

    issue(64'h3FF0000000000000, 64'h3FF0000000000000);
    chk("one_data", bus.out_data, 64'h3FF0000000000000);
    chk("one_flags", 64'(bus.out_flags), 64'h0);
    retire_op();
    chk("one_fflags", 64'(fflags), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
